// File: rtl/wallace_pipe_8x8_if.sv
// rtl/wallace_pipe_8x8_if.sv - operand/row-pair handshake bundle for the Wallace multiplier front end
interface wallace_pipe_8x8_if #(
    parameter int WIDTH = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_sum;
    logic [2*WIDTH-1:0]   out_carry;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_carry
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_carry
    );
endinterface

// File: rtl/wallace_pipe_8x8.sv
// rtl/wallace_pipe_8x8.sv - 3-stage pipelined 8x8 Wallace tree reducing partial products to sum/carry rows
module wallace_pipe_8x8 #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    wallace_pipe_8x8_if.slave  bus
);
    localparam int PW = 2 * WIDTH;

    typedef logic [PW-1:0] row_t;

    if (WIDTH != 8 || LATENCY != 3) begin : g_unsupported
        $error("wallace_pipe_8x8 supports only WIDTH=8, LATENCY=3");
    end

    function automatic row_t csa_sum(row_t x, row_t y, row_t z);
        return x ^ y ^ z;
    endfunction

    // Carry leaves bit 15 silently; the product never needs it.
    function automatic row_t csa_carry(row_t x, row_t y, row_t z);
        return ((x & y) | (x & z) | (y & z)) << 1;
    endfunction

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    row_t pp_d   [WIDTH];
    row_t pp_q   [WIDTH];
    row_t l1     [6];
    row_t s2_d   [4];
    row_t s2_q   [4];
    row_t l3_sum, l3_carry;
    row_t sum_d, carry_d;
    row_t sum_q, carry_q;

    // Each stage may load when it is empty or its successor is taking its item.
    assign adv3 = !v3 || bus.out_ready;
    assign adv2 = !v2 || adv3;
    assign adv1 = !v1 || adv2;

    assign bus.in_ready  = adv1;
    assign bus.out_valid = v3;
    assign bus.out_sum   = sum_q;
    assign bus.out_carry = carry_q;

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp_d[i] = row_t'(bus.in_a & {WIDTH{bus.in_b[i]}}) << i;
        end
    end

    always_comb begin
        l1[0]   = csa_sum  (pp_q[0], pp_q[1], pp_q[2]);
        l1[1]   = csa_carry(pp_q[0], pp_q[1], pp_q[2]);
        l1[2]   = csa_sum  (pp_q[3], pp_q[4], pp_q[5]);
        l1[3]   = csa_carry(pp_q[3], pp_q[4], pp_q[5]);
        l1[4]   = pp_q[6];
        l1[5]   = pp_q[7];
        s2_d[0] = csa_sum  (l1[0], l1[1], l1[2]);
        s2_d[1] = csa_carry(l1[0], l1[1], l1[2]);
        s2_d[2] = csa_sum  (l1[3], l1[4], l1[5]);
        s2_d[3] = csa_carry(l1[3], l1[4], l1[5]);
    end

    always_comb begin
        l3_sum   = csa_sum  (s2_q[0], s2_q[1], s2_q[2]);
        l3_carry = csa_carry(s2_q[0], s2_q[1], s2_q[2]);
        sum_d    = csa_sum  (l3_sum, l3_carry, s2_q[3]);
        carry_d  = csa_carry(l3_sum, l3_carry, s2_q[3]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            sum_q   <= '0;
            carry_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                pp_q[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                s2_q[i] <= '0;
            end
        end else begin
            if (adv1) begin
                v1 <= bus.in_valid;
                if (bus.in_valid) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        pp_q[i] <= pp_d[i];
                    end
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    for (int i = 0; i < 4; i++) begin
                        s2_q[i] <= s2_d[i];
                    end
                end
            end
            if (adv3) begin
                v3 <= v2;
                if (v2) begin
                    sum_q   <= sum_d;
                    carry_q <= carry_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_wallace_pipe_8x8.sv
// tb/tb_wallace_pipe_8x8.sv - directed self-checking bench for wallace_pipe_8x8
module tb_wallace_pipe_8x8;
    logic clk;
    logic rst_n;

    wallace_pipe_8x8_if #(.WIDTH(8)) bus ();

    wallace_pipe_8x8 #(.WIDTH(8), .LATENCY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          pass_cnt = 0;
    int          total    = 0;
    int          n_in     = 0;
    int          n_out    = 0;
    logic        last_in_fire;
    logic [15:0] sb  [$];
    logic [15:0] got [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // One clock: score the transfers visible now, then advance to the next falling edge.
    task automatic tick();
        logic [15:0] p;
        logic [15:0] s;
        logic [31:0] e;
        #1;
        last_in_fire = bus.in_valid && bus.in_ready;
        if (last_in_fire) begin
            p = {8'h00, bus.in_a} * {8'h00, bus.in_b};
            sb.push_back(p);
            n_in++;
        end
        if (bus.out_valid && bus.out_ready) begin
            s = bus.out_sum + bus.out_carry;
            e = (sb.size() != 0) ? {16'h0000, sb.pop_front()} : 32'hDEAD_0000;
            chk("result", {16'h0000, s}, e);
            got.push_back(s);
            n_out++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int cycles);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (cycles) tick();
    endtask

    logic [7:0] bp_a [5];
    logic [7:0] bp_b [5];
    logic [15:0] bp_exp [5];
    logic [15:0] held_sum, held_carry;
    logic        have_hold;
    int          idx, n_in0, n_out0, cyc;

    initial begin
        bp_a = '{8'd3, 8'd12, 8'h00, 8'd200, 8'd1};
        bp_b = '{8'd7, 8'd12, 8'h99, 8'd2,   8'd1};
        bp_exp = '{16'd21, 16'd144, 16'd0, 16'd400, 16'd1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_sum",   {16'b0, bus.out_sum},   32'd0);
        chk("rst_out_carry", {16'b0, bus.out_carry}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Single item: out_valid high only in the third cycle after acceptance.
        got.delete();
        bus.in_valid = 1'b1;
        bus.in_a     = 8'hFF;
        bus.in_b     = 8'hFF;
        tick();
        chk("single_accept", {31'b0, last_in_fire}, 32'd1);
        bus.in_valid = 1'b0;
        bus.in_a     = 8'h5A;
        chk("single_lat1", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("single_lat2", {31'b0, bus.out_valid}, 32'd0);
        tick();
        chk("single_lat3", {31'b0, bus.out_valid}, 32'd1);
        chk("single_value", {16'b0, 16'(bus.out_sum + bus.out_carry)}, 32'h0000_FE01);
        tick();
        chk("single_drop", {31'b0, bus.out_valid}, 32'd0);
        drain(3);
        chk("single_count", got.size(), 32'd1);

        // Streaming: 256 back-to-back items.
        got.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'(i);
            bus.in_b     = 8'(255 - i);
            #1;
            chk("stream_in_ready", {31'b0, bus.in_ready}, 32'd1);
            tick();
        end
        drain(5);
        chk("stream_count", got.size(), 32'd256);
        chk("stream_sb_empty", sb.size(), 32'd0);

        // Backpressure: 3 items fill the pipe, then in_ready falls and outputs hold.
        got.delete();
        bus.out_ready = 1'b0;
        idx       = 0;
        have_hold = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = bp_a[idx];
            bus.in_b     = bp_b[idx];
            tick();
            if (last_in_fire) idx++;
            if (bus.out_valid) begin
                if (!have_hold) begin
                    held_sum   = bus.out_sum;
                    held_carry = bus.out_carry;
                    have_hold  = 1'b1;
                end else begin
                    chk("bp_hold_sum",   {16'b0, bus.out_sum},   {16'b0, held_sum});
                    chk("bp_hold_carry", {16'b0, bus.out_carry}, {16'b0, held_carry});
                end
            end
        end
        chk("bp_accepted", idx, 32'd3);
        #1;
        chk("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            bus.in_valid = (idx < 5);
            bus.in_a     = bp_a[(idx < 5) ? idx : 4];
            bus.in_b     = bp_b[(idx < 5) ? idx : 4];
            tick();
            if (last_in_fire) idx++;
        end
        chk("bp_count", got.size(), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk("bp_order", {16'b0, (k < got.size()) ? got[k] : 16'hFFFF}, {16'b0, bp_exp[k]});
        end

        // Bubbles with random backpressure.
        n_in0  = n_in;
        n_out0 = n_out;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid  = (c % 2 == 0);
            bus.in_a      = 8'($urandom);
            bus.in_b      = 8'($urandom);
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        drain(8);
        chk("bubble_count", n_out - n_out0, n_in - n_in0);
        chk("bubble_sb_empty", sb.size(), 32'd0);

        // Asynchronous reset with three items in flight.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 8'(k + 9);
            bus.in_b     = 8'(k + 3);
            tick();
        end
        bus.in_valid = 1'b0;
        chk("arst_pre_valid", {31'b0, bus.out_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("arst_out_sum",   {16'b0, bus.out_sum},   32'd0);
        chk("arst_out_carry", {16'b0, bus.out_carry}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
        got.delete();
        drain(6);
        chk("arst_no_stale", got.size(), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_a     = 8'h80;
        bus.in_b     = 8'h02;
        tick();
        drain(5);
        chk("arst_new_count", got.size(), 32'd1);
        chk("arst_new_value", {16'b0, (got.size() != 0) ? got[0] : 16'hFFFF}, 32'h0000_0100);

        // Operand sweep with random backpressure.
        idx = 0;
        cyc = 0;
        while (idx < 512 && cyc < 4000) begin
            bus.in_valid  = 1'b1;
            bus.in_a      = 8'(idx >> 1);
            bus.in_b      = idx[0] ? ~8'(idx >> 1) : 8'(((idx >> 1) * 37 + 11) & 255);
            bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            if (last_in_fire) idx++;
            cyc++;
        end
        drain(8);
        chk("sweep_accepted", idx, 32'd512);
        chk("sweep_sb_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
